// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit.
// Optional statistics counters are enabled by BPU_STATS_EN.
package bpu_pkg;

  typedef enum logic {
    BPU_IDLE,
    BPU_CLEAR
  } bpu_state_t;

  localparam int unsigned PC_INC = 4;

  function automatic int unsigned ctr_init(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down next-value logic for a direction counter.
// Shared by the single update path, not replicated per entry.
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             up,
  output logic [CTR_W-1:0] nxt
);

  always_comb begin
    nxt = ctr;
    if (up) begin
      if (ctr != '1) nxt = ctr + CTR_W'(1);
    end else begin
      if (ctr != '0) nxt = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with saturating direction counters and clear sweep.
// Define BPU_STATS_EN to add lookup/mispredict statistics counters.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 64,
  parameter int TAG_W = 16,
  parameter int CTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            clear_req,
  output logic            busy
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CTR_W-1:0] CTR_WT = CTR_W'(ctr_init(CTR_W));

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [CTR_W-1:0] ctr_q    [DEPTH];

  bpu_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, upd_we;
  logic [CTR_W-1:0] ctr_nxt;

  assign busy  = (state_q == BPU_CLEAR);

  assign l_idx = lookup_pc[2 +: IDX_W];
  assign l_tag = lookup_pc[2+IDX_W +: TAG_W];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign pred_taken  = l_hit && ctr_q[l_idx][CTR_W-1] && !busy;
  assign pred_target = pred_taken ? target_q[l_idx]
                                  : lookup_pc + XLEN'(PC_INC);

  assign mispredict = upd_valid &&
    ((upd_taken != upd_pred_taken) ||
     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target
                                 : upd_pc + XLEN'(PC_INC);

  assign u_idx  = upd_pc[2 +: IDX_W];
  assign u_tag  = upd_pc[2+IDX_W +: TAG_W];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd_we = upd_valid && !busy;

  sat_counter #(.CTR_W(CTR_W)) u_ctr (
    .ctr (ctr_q[u_idx]),
    .up  (upd_taken),
    .nxt (ctr_nxt)
  );

  // Payload needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (upd_we) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_nxt;
        if (upd_taken) target_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (busy) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (upd_we && upd_taken && !u_hit) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BPU_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      BPU_IDLE: begin
        if (clear_req) begin
          state_d = BPU_CLEAR;
          ptr_d   = '0;
        end
      end
      BPU_CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) state_d = BPU_IDLE;
      end
      default: state_d = BPU_IDLE;
    endcase
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lookup_valid) stat_lookups <= stat_lookups + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic unused_lookup_valid;
  assign unused_lookup_valid = lookup_valid;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (default parameters).
// Covers BPU_STATS_EN counters when that macro is defined.
module tb_branch_predict_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            lookup_valid;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            clear_req;
  logic            busy;
`ifdef BPU_STATS_EN
  logic [31:0]     stat_lookups;
  logic [31:0]     stat_mispredicts;
`endif

  branch_predict_unit dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_valid    (lookup_valid),
    .lookup_pc       (lookup_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .clear_req       (clear_req),
    .busy            (busy)
`ifdef BPU_STATS_EN
    ,
    .stat_lookups    (stat_lookups),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] lpc;
    logic        uv;
    logic [63:0] upc;
    logic        ut;
    logic [63:0] utgt;
    logic        upt;
    logic [63:0] uptgt;
    logic        e_pt;
    logic [63:0] e_ptgt;
    logic        e_mp;
    logic [63:0] e_rd;
  } vec_t;

  vec_t sbq[$];
  vec_t tv[22];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(
    input logic [63:0] lpc, input logic uv, input logic [63:0] upc,
    input logic ut, input logic [63:0] utgt, input logic upt,
    input logic [63:0] uptgt, input logic e_pt, input logic [63:0] e_ptgt,
    input logic e_mp, input logic [63:0] e_rd);
    vec_t v;
    v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
    v.e_mp = e_mp; v.e_rd = e_rd;
    return v;
  endfunction

  function automatic vec_t lk(input logic [63:0] pc,
                              input logic e_pt, input logic [63:0] e_tgt);
    return mk(pc, 0, 0, 0, 0, 0, 0, e_pt, e_tgt, 0, 64'h4);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    lookup_valid    = 1'b1;
    lookup_pc       = v.lpc;
    upd_valid       = v.uv;
    upd_pc          = v.upc;
    upd_taken       = v.ut;
    upd_target      = v.utgt;
    upd_pred_taken  = v.upt;
    upd_pred_target = v.uptgt;
    sbq.push_back(v);
    @(negedge clk);
    e = sbq.pop_front();
    chk({tag, ".pred_taken"}, 64'(pred_taken), 64'(e.e_pt));
    chk({tag, ".pred_target"}, pred_target, e.e_ptgt);
    chk({tag, ".mispredict"}, 64'(mispredict), 64'(e.e_mp));
    chk({tag, ".redirect_pc"}, redirect_pc, e.e_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    tv[0]  = lk(64'h100, 0, 64'h104);
    tv[1]  = mk(64'h100, 1, 64'h100, 1, 64'h200, 0, 64'h0,   0, 64'h104, 1, 64'h200);
    tv[2]  = mk(64'h100, 1, 64'h100, 1, 64'h200, 1, 64'h200, 1, 64'h200, 0, 64'h200);
    tv[3]  = tv[2];
    tv[4]  = tv[2];
    tv[5]  = mk(64'h100, 1, 64'h100, 0, 64'h0,   1, 64'h200, 1, 64'h200, 1, 64'h104);
    tv[6]  = tv[5];
    tv[7]  = lk(64'h100, 0, 64'h104);
    tv[8]  = mk(64'h100, 1, 64'h100, 0, 64'h0,   0, 64'h0,   0, 64'h104, 0, 64'h104);
    tv[9]  = mk(64'h100, 1, 64'h100, 1, 64'h200, 1, 64'h300, 0, 64'h104, 1, 64'h200);
    tv[10] = mk(64'h100, 1, 64'h100, 1, 64'h200, 0, 64'h0,   0, 64'h104, 1, 64'h200);
    tv[11] = lk(64'h100, 1, 64'h200);
    tv[12] = mk(64'h100, 1, 64'h200, 1, 64'h280, 0, 64'h0,   1, 64'h200, 1, 64'h280);
    tv[13] = lk(64'h100, 0, 64'h104);
    tv[14] = lk(64'h200, 1, 64'h280);
    tv[15] = mk(64'h300, 1, 64'h300, 0, 64'h0,   0, 64'h0,   0, 64'h304, 0, 64'h304);
    tv[16] = lk(64'h300, 0, 64'h304);
    tv[17] = lk(64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0);
    tv[18] = mk(64'h1004, 1, 64'h1004, 1, 64'h2000, 0, 64'h0, 0, 64'h1008, 1, 64'h2000);
    tv[19] = lk(64'h1004, 1, 64'h2000);
    tv[20] = mk(64'hA0, 1, 64'hA0, 1, 64'h3000, 0, 64'h0, 0, 64'hA4, 1, 64'h3000);
    tv[21] = lk(64'hA0, 1, 64'h3000);

    rst = 1'b1;
    lookup_valid = 1'b0; lookup_pc = 64'h100;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0; clear_req = 1'b0;
    #12;
    chk("reset.busy", 64'(busy), 64'h0);
    chk("reset.pred_taken", 64'(pred_taken), 64'h0);
    chk("reset.pred_target", pred_target, 64'h104);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 22; i++) step(tv[i], $sformatf("vec%0d", i));

    // Full clear sweep with a re-request and a dropped update inside it
    lookup_pc = 64'h200;
    upd_valid = 1'b0;
    pulse_clear();
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (cnt == 5) chk("sweep.pred_taken", 64'(pred_taken), 64'h0);
      if (cnt == 10) clear_req = 1'b1;
      if (cnt == 11) clear_req = 1'b0;
      if (cnt == 30) begin
        upd_valid = 1'b1; upd_pc = 64'h400; upd_taken = 1'b1;
        upd_target = 64'h600; upd_pred_taken = 1'b0;
        #1;
        chk("sweep.mispredict", 64'(mispredict), 64'h1);
      end
      if (cnt == 31) upd_valid = 1'b0;
    end
    chk("sweep.length", 64'(cnt), 64'd64);
    @(posedge clk);
    #1;
    step(lk(64'h200, 0, 64'h204), "postclr200");
    step(lk(64'h1004, 0, 64'h1008), "postclr1004");
    step(lk(64'h400, 0, 64'h404), "dropped400");
    chk("idle.busy", 64'(busy), 64'h0);

    // Reset in the middle of a sweep
    step(tv[20], "retrainA0");
    step(tv[21], "hitA0");
    pulse_clear();
    for (int n = 0; n < 20; n++) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(lk(64'hA0, 0, 64'hA4), "postrstA0");

`ifdef BPU_STATS_EN
    lookup_valid = 1'b0; upd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lookup_valid = 1'b1; lookup_pc = 64'h800;
      upd_valid = (i < 3); upd_pc = 64'h800; upd_taken = 1'b1;
      upd_target = 64'h900; upd_pred_taken = 1'b0;
      @(posedge clk);
      #1;
    end
    lookup_valid = 1'b0; upd_valid = 1'b0;
    chk("stat.lookups", 64'(stat_lookups), 64'd10);
    chk("stat.mispredicts", 64'(stat_mispredicts), 64'd3);
    pulse_clear();
    wait_idle(cnt);
    chk("stat.clear_lookups", 64'(stat_lookups), 64'd10);
    chk("stat.clear_mispredicts", 64'(stat_mispredicts), 64'd3);
    rst = 1'b1;
    #1;
    chk("stat.rst_lookups", 64'(stat_lookups), 64'd0);
    chk("stat.rst_mispredicts", 64'(stat_mispredicts), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
